// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: PC, ROM addressing, one-entry output buffer, redirects.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirects raise a sticky fault and halt.
module fetch_sequencer #(
  parameter int                ADDR_W   = 7,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 7'h00,
  parameter logic [ADDR_W-1:0] LAST_PC  = 7'h48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halt,
  output logic              fault
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, inst_pc_nxt;
  logic [DATA_W-1:0] inst_nxt;
  logic              valid_nxt, fault_q, fault_nxt;
  logic              misalign, slot_free;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign = |redirect_pc[1:0];
`else
  assign misalign = 1'b0;
`endif

  // buffer can take a new word if empty or being consumed this cycle
  assign slot_free = !inst_valid || inst_ready;

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    inst_nxt    = inst;
    inst_pc_nxt = inst_pc;
    valid_nxt   = inst_valid;
    fault_nxt   = fault_q;
    if (inst_valid && inst_ready) valid_nxt = 1'b0;
    if (redirect) begin
      valid_nxt = 1'b0;
      if (misalign) begin
        fault_nxt = 1'b1;
        state_nxt = HALT;
      end else begin
        pc_nxt = redirect_pc & ALIGN_MASK;
        if (state != IDLE) state_nxt = RUN;
      end
    end else begin
      case (state)
        IDLE: if (enable) state_nxt = RUN;
        RUN: begin
          if (enable && slot_free) begin
            if (pc <= LAST_PC) begin
              inst_nxt    = rom_data;
              inst_pc_nxt = pc;
              valid_nxt   = 1'b1;
              pc_nxt      = pc + ADDR_W'(4);
            end else begin
              state_nxt = HALT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      inst       <= inst_nxt;
      inst_pc    <= inst_pc_nxt;
      inst_valid <= valid_nxt;
      fault_q    <= fault_nxt;
    end
  end

  assign rom_addr = pc;
  assign halt     = (state == HALT);
  assign fault    = fault_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: queue-based reference model, per-cycle expected
// snapshots pushed by the driver and popped/compared by an independent monitor.
module tb_fetch_sequencer;
  localparam int LAST = 'h48;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        enable = 1'b0, inst_ready = 1'b0, redirect = 1'b0;
  logic [6:0]  redirect_pc = '0, rom_addr, inst_pc;
  logic [31:0] rom_data, inst;
  logic        inst_valid, halt, fault;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rom_addr(rom_addr), .rom_data(rom_data),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [6:0] a);
    case (a)
      7'h00: rom_word = 32'h00450693;
      7'h04: rom_word = 32'h00100713;
      7'h08: rom_word = 32'h00b76463;
      7'h10: rom_word = 32'h0006a803;
      7'h1c: rom_word = 32'hffc62883;
      7'h44: rom_word = 32'h00468693;
      7'h48: rom_word = 32'hfc1ff06f;
      default: rom_word = 32'h5a00_0000 ^ {25'd0, a} ^ {a, 25'd0};
    endcase
  endfunction

  assign rom_data = rom_word(rom_addr);

  typedef struct {
    logic        v;
    logic [31:0] i;
    logic [6:0]  ip;
    logic [6:0]  ra;
    logic        h;
    logic        f;
  } exp_t;
  exp_t q[$];

  int vecs = 0, errs = 0;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %h exp %h at %0t", n, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle / 1 run / 2 halt, buffer held as a queue of at most one word
  int          m_mode = 0, m_pc = 0;
  bit          m_fault = 0;
  logic [31:0] bq_d[$];
  logic [6:0]  bq_pc[$];

  task automatic m_reset();
    m_mode = 0; m_pc = 0; m_fault = 0;
    bq_d.delete(); bq_pc.delete();
  endtask

  task automatic m_step(input bit en, input bit rdy, input bit rd, input logic [6:0] rpc);
    if (bq_d.size() != 0 && rdy) begin
      void'(bq_d.pop_front()); void'(bq_pc.pop_front());
    end
    if (rd) begin
      bq_d.delete(); bq_pc.delete();
      if (ALIGN && rpc[1:0] != 2'b00) begin
        m_fault = 1; m_mode = 2;
      end else begin
        m_pc = int'(rpc) & 'h7C;
        if (m_mode != 0) m_mode = 1;
      end
    end else if (m_mode == 0) begin
      if (en) m_mode = 1;
    end else if (m_mode == 1 && en && bq_d.size() == 0) begin
      if (m_pc <= LAST) begin
        bq_d.push_back(rom_word(7'(m_pc)));
        bq_pc.push_back(7'(m_pc));
        m_pc = (m_pc + 4) % 128;
      end else m_mode = 2;
    end
  endtask

  // One clock: publish expected pre-edge state, drive inputs for the coming edge, advance model
  task automatic cyc(input bit en, input bit rdy, input bit rd, input logic [6:0] rpc);
    exp_t e;
    @(negedge clk);
    e.v  = (bq_d.size() != 0);
    e.i  = e.v ? bq_d[0] : 32'h0;
    e.ip = e.v ? bq_pc[0] : 7'h0;
    e.ra = 7'(m_pc);
    e.h  = (m_mode == 2);
    e.f  = m_fault;
    q.push_back(e);
    enable = en; inst_ready = rdy; redirect = rd; redirect_pc = rpc;
    m_step(en, rdy, rd, rpc);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'h00);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'h0);
    chk({tag, "_halt"}, 32'(halt), 32'h0);
    chk({tag, "_fault"}, 32'(fault), 32'h0);
    chk({tag, "_inst"}, inst, 32'h0);
  endtask

  task automatic mid_reset();
    #3;
    rst_n = 1'b0;
    enable = 0; inst_ready = 0; redirect = 0; redirect_pc = '0;
    #1;
    reset_checks("async_reset");
    m_reset();
    q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: compares DUT outputs with the next expected snapshot
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("inst_valid", 32'(inst_valid), 32'(e.v));
        chk("rom_addr", 32'(rom_addr), 32'(e.ra));
        chk("halt", 32'(halt), 32'(e.h));
        chk("fault", 32'(fault), 32'(e.f));
        if (e.v) begin
          chk("inst", inst, e.i);
          chk("inst_pc", 32'(inst_pc), 32'(e.ip));
        end
      end
    end
  end

  initial begin
    logic [6:0] rpc;
    #3;
    reset_checks("reset");
    @(negedge clk);
    #1 rst_n = 1'b1;

    // straight line
    cyc(1, 1, 0, 7'h00);
    repeat (4) cyc(1, 1, 0, 7'h00);
    // backpressure from pc 0
    cyc(1, 1, 1, 7'h00);
    repeat (4) cyc(1, 0, 0, 7'h00);
    repeat (2) cyc(1, 1, 0, 7'h00);
    // redirect while holding a word
    cyc(1, 0, 1, 7'h10);
    repeat (3) cyc(1, 1, 0, 7'h00);
    // enable low pauses while buffer drains
    repeat (2) cyc(0, 1, 0, 7'h00);
    // end of program then resume
    cyc(1, 1, 1, 7'h44);
    repeat (5) cyc(1, 1, 0, 7'h00);
    cyc(1, 0, 1, 7'h1c);
    repeat (3) cyc(1, 1, 0, 7'h00);
    // misaligned redirect
    cyc(1, 1, 1, 7'h12);
    repeat (3) cyc(1, 1, 0, 7'h00);
    cyc(1, 1, 1, 7'h10);
    repeat (2) cyc(1, 1, 0, 7'h00);
    // redirect in IDLE after reset keeps IDLE
    mid_reset();
    cyc(0, 1, 1, 7'h08);
    repeat (3) cyc(1, 1, 0, 7'h00);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) mid_reset();
      rpc = ($urandom_range(0, 1) != 0) ? 7'($urandom_range('h38, 'h7f)) : 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, rpc);
    end

    repeat (2) @(negedge clk);
    #4;
    if (q.size() != 0) chk("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
